pipe_skid_reg: RTL
==================

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 The block SHALL take parameter DW, default 64, meaning total payload width in bits.
REQ-002 The block SHALL take parameter TW, default 32, meaning tag width (payload MSBs, e.g. PC); TW <= DW.
REQ-003 The block SHALL take parameter BUB_DATA, default 32'h0340_0000 (NOP), meaning the low DW-TW bits of an injected bubble.
REQ-004 The block SHALL take parameter BUB_EN, default 1, meaning 1 = flush injects a bubble and 0 = flush only empties.
REQ-005 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst_i, input, 1 bit: reset, synchronous and active-low.
REQ-007 The block SHALL have port in_valid_i, input, 1 bit: upstream beat valid.
REQ-008 The block SHALL have port in_ready_o, output, 1 bit: block can accept a beat.
REQ-009 The block SHALL have port in_data_i, input, DW bits: upstream payload {tag, data}.
REQ-010 The block SHALL have port out_valid_o, output, 1 bit: downstream beat valid.
REQ-011 The block SHALL have port out_ready_i, input, 1 bit: downstream accepts.
REQ-012 The block SHALL have port out_data_o, output, DW bits: downstream payload.
REQ-013 The block SHALL have port flush_i, input, 1 bit: branch/jump taken; discard contents.
REQ-014 The block SHALL have port hold_i, input, 1 bit: structural hazard; freeze all state.
REQ-015 The block SHALL have port occ_o, output, 2 bits: entry count, 0..2.

Function
REQ-016 Accept (acc) SHALL occur exactly when in_valid_i && in_ready_o, and deliver (dlv) exactly when out_valid_o && out_ready_i; there SHALL be no other transfers.
REQ-017 Storage SHALL be a main entry (drives out_*) plus one skid entry, each with a valid bit.
REQ-018 Beats SHALL leave in arrival order with 1-cycle latency from accept into an empty main entry.
REQ-019 in_ready_o SHALL equal ~skid_v && ~hold_i, with no combinational path from out_ready_i.
REQ-020 out_valid_o SHALL equal main_v && ~hold_i, and out_data_o SHALL equal main_d at all times.
REQ-021 With main empty, acc SHALL load main.
REQ-022 With main full and dlv, skid empty, acc SHALL load main; with no acc, main SHALL empty.
REQ-023 With main full, no dlv, acc SHALL load skid.
REQ-024 With skid full and dlv, main SHALL take skid and skid SHALL empty; with skid full and no dlv, state SHALL be unchanged.
REQ-025 last_tag SHALL load in_data_i[DW-1 -: TW] on every acc.
REQ-026 hold_i=1 without flush SHALL leave all state, including last_tag, unchanged.
REQ-027 flush_i SHALL take priority over hold_i and over any acc in the same cycle; the incoming beat is dropped and last_tag is unchanged.
REQ-028 On flush with BUB_EN=1, the next cycle SHALL have main = {last_tag, BUB_DATA} valid and skid empty.
REQ-029 On flush with BUB_EN=0, the next cycle SHALL have both entries empty.
REQ-030 occ_o SHALL equal main_v + skid_v, and skid_v=1 SHALL imply main_v=1 at all times.

Reset
REQ-031 On rst_i=0 at a clock edge, main_v, skid_v, main_d, skid_d and last_tag SHALL clear to 0, overriding flush_i and hold_i.
REQ-032 After reset, outputs SHALL be out_valid_o=0, out_data_o=0, occ_o=0, and in_ready_o = ~hold_i.
REQ-033 Reset mid-stream SHALL discard buffered beats without emitting a bubble.

Structure
REQ-034 The NOP encoding, the IF-to-ID bus width and the PC width SHALL live in the shared common header/package; the block SHALL contain no local copies.
REQ-035 The block SHALL be self-contained with no sub-module; IF/ID instantiates it with DW = IF2IDBusSize and TW = 32.

Verification
REQ-036 Streaming: with out_ready_i=1, accepts of 0x1000_0000_0000_0001..0003 SHALL appear on out_data_o one cycle later in order, with occ_o never exceeding 1.
REQ-037 Backpressure: with out_ready_i=0, A then B SHALL give occ_o=2 and in_ready_o=0; on release, A then B SHALL emit on consecutive cycles.
REQ-038 Flush bubble: after accepting tag 0x1C00_0010 and asserting flush_i with in_valid_i=1, next cycle out_data_o SHALL be 0x1C00_0010_0340_0000 and occ_o=1.
REQ-039 Hold: hold_i=1 for 3 cycles with occ_o=2 SHALL keep out_valid_o=0, in_ready_o=0 and occ_o=2, and contents SHALL be intact after release.
REQ-040 Flush during hold with BUB_EN=0 SHALL give occ_o=0 next cycle; rst_i=0 with occ_o=2 SHALL give occ_o=0 and out_data_o=0.

Source files
------------

// File: rtl/pipe_skid_reg_pkg.sv
// Shared IF/ID definitions: instruction bus geometry and the NOP encoding used for bubbles.
package pipe_skid_reg_pkg;

   localparam int unsigned PC_W           = 32;
   localparam int unsigned IF2ID_BUS_SIZE = 64;
   localparam logic [31:0] NOP_INSN       = 32'h0340_0000;

endpackage : pipe_skid_reg_pkg

// File: rtl/pipe_skid_reg.sv
// Two-entry skid pipeline register between IF and ID, with flush-driven bubble
// injection and a hold input that freezes all state.
module pipe_skid_reg
   import pipe_skid_reg_pkg::*;
#(
   parameter int unsigned   DW       = IF2ID_BUS_SIZE,
   parameter int unsigned   TW       = PC_W,
   parameter logic [DW-1:0] BUB_DATA = DW'(NOP_INSN),
   parameter bit            BUB_EN   = 1'b1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          in_valid_i,
   output logic          in_ready_o,
   input  logic [DW-1:0] in_data_i,
   output logic          out_valid_o,
   input  logic          out_ready_i,
   output logic [DW-1:0] out_data_o,
   input  logic          flush_i,
   input  logic          hold_i,
   output logic [1:0]    occ_o
);

   // Bubble keeps the tag bits of the last accepted beat over the NOP payload.
   localparam logic [DW-1:0] LOW_MASK = ~({DW{1'b1}} << (DW - TW));

   logic          main_v_q, main_v_d;
   logic          skid_v_q, skid_v_d;
   logic [DW-1:0] main_d_q, main_d_d;
   logic [DW-1:0] skid_d_q, skid_d_d;
   logic [TW-1:0] last_tag_q, last_tag_d;

   logic          acc_c;
   logic          dlv_c;
   logic [DW-1:0] bubble_c;

   assign in_ready_o  = ~skid_v_q & ~hold_i;
   assign out_valid_o = main_v_q & ~hold_i;
   assign out_data_o  = main_d_q;
   assign occ_o       = {1'b0, main_v_q} + {1'b0, skid_v_q};

   assign acc_c    = in_valid_i & in_ready_o;
   assign dlv_c    = out_valid_o & out_ready_i;
   assign bubble_c = (BUB_DATA & LOW_MASK) | (DW'(last_tag_q) << (DW - TW));

   // Next-state: flush wins; hold needs no branch since it already blocks acc and dlv.
   always_comb begin
      main_v_d   = main_v_q;
      skid_v_d   = skid_v_q;
      main_d_d   = main_d_q;
      skid_d_d   = skid_d_q;
      last_tag_d = last_tag_q;

      if (flush_i) begin
         skid_v_d = 1'b0;
         main_v_d = BUB_EN;
         if (BUB_EN) begin
            main_d_d = bubble_c;
         end
      end else begin
         if (acc_c) begin
            last_tag_d = in_data_i[DW-1 -: TW];
         end

         if (!main_v_q) begin
            if (acc_c) begin
               main_v_d = 1'b1;
               main_d_d = in_data_i;
            end
         end else if (skid_v_q) begin
            if (dlv_c) begin
               main_d_d = skid_d_q;
               skid_v_d = 1'b0;
            end
         end else if (dlv_c) begin
            main_v_d = acc_c;
            if (acc_c) begin
               main_d_d = in_data_i;
            end
         end else if (acc_c) begin
            skid_v_d = 1'b1;
            skid_d_d = in_data_i;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         main_v_q   <= 1'b0;
         skid_v_q   <= 1'b0;
         main_d_q   <= '0;
         skid_d_q   <= '0;
         last_tag_q <= '0;
      end else begin
         main_v_q   <= main_v_d;
         skid_v_q   <= skid_v_d;
         main_d_q   <= main_d_d;
         skid_d_q   <= skid_d_d;
         last_tag_q <= last_tag_d;
      end
   end

endmodule : pipe_skid_reg
